fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction-register stage directly upstream of the combinational instruction ROM.
- Drives the 8-bit ROM address, captures the 9-bit instruction word into an instruction register (IR) for the decoder, and handles start, stall, jump/branch redirect and halt.
- Redirects come from the execute stage and are applied the next cycle. Fetch down the squashed (wrong) path is suppressed by a one-cycle bubble.

Parameters:
- ADDR_W, 8: PC/ROM address width.
- INSTR_W, 9: instruction width.
- HALT_OP, 4'b1111: opcode in instr[INSTR_W-1:INSTR_W-4] that halts fetch.
- NOP_WORD, 9'b0_0000_0000: value loaded into IR on squash/reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetch at start_addr.
- start_addr  in  ADDR_W  PC loaded on start.
- stall  in  1  hold PC and IR (downstream not ready).
- redirect  in  1  taken jump/branch from execute.
- redirect_addr  in  ADDR_W  target PC for redirect.
- rom_addr  out  ADDR_W  address to instruction ROM (= PC, combinational from register).
- rom_instr  in  INSTR_W  instruction returned by ROM, same cycle.
- ir  out  INSTR_W  registered instruction to decoder.
- ir_pc  out  ADDR_W  PC of the instruction held in ir.
- ir_valid  out  1  ir holds a live instruction.
- running  out  1  FSM in RUN.
- done  out  1  FSM in HALT.

Behaviour:
- Reset (synchronous, highest priority): PC=0, ir=NOP_WORD, ir_pc=0, ir_valid=0, state=IDLE, running=0, done=0.
- States: IDLE, RUN, HALT (2-bit encoded, registered). running=(state==RUN), done=(state==HALT).
- IDLE: start=1 → PC<=start_addr, state<=RUN, ir_valid stays 0. Stall/redirect are ignored.
- RUN, priority order per cycle:
  1. redirect=1 → PC<=redirect_addr, ir<=NOP_WORD, ir_valid<=0. This squashes the word at the current PC and applies even when stall=1.
  2. stall=1 → PC, ir, ir_pc, ir_valid all hold.
  3. Fetched opcode==HALT_OP → ir<=rom_instr, ir_pc<=PC, ir_valid<=1, PC holds, state<=HALT.
  4. Otherwise → ir<=rom_instr, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
- Latency: instruction at address A appears on ir one cycle after rom_addr==A. Redirect-to-first-valid-target is 2 cycles (1 bubble).
- PC arithmetic is modulo 2^ADDR_W: 255+1 wraps to 0, with no flag.
- HALT: ir_valid<=0 in the cycle after entry, so the halt word is presented exactly once. PC frozen. start=1 → PC<=start_addr, state<=RUN (restart). redirect is ignored in HALT.
- start while in RUN is ignored.
- Reset mid-RUN: the next edge returns all outputs to reset values; the in-flight instruction is discarded.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs cycle_count (16) and fetch_count (16), both reset to 0 and restarted to 0 on start.
  - cycle_count increments every RUN cycle.
  - fetch_count increments on each cycle ir_valid is loaded with 1.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then start, start_addr=0, ROM holds 16 sequential non-halt words → ir_pc = 0,1,2,… on consecutive cycles with ir_valid=1 from the 2nd cycle after start; rom_addr leads ir_pc by one.
- At PC=5 assert stall for 3 cycles → rom_addr stays 5, ir/ir_pc (=4) held, ir_valid held 1; resumes with ir_pc=5 after stall drops.
- redirect=1 with redirect_addr=0 while PC=15 → next cycle ir_valid=0, ir=NOP_WORD, rom_addr=0; following cycle ir_pc=0, ir_valid=1. Repeat with stall=1 simultaneously → same result (redirect wins).
- ROM word 9'b1111_00000 at address 3 → ir=9'b1111_00000 with ir_pc=3 for one cycle, then ir_valid=0, done=1, running=0, rom_addr stuck at 3. Pulse start, start_addr=8 → running=1, fetch resumes at 8.
- start_addr=254 with no halt → ir_pc sequence 254,255,0,1 (wrap).
- Assert reset mid-RUN at PC=7 → next cycle ir_valid=0, rom_addr=0, running=0. With FETCH_PERF_EN defined, cycle_count and fetch_count read 0 after reset and after a restart via start.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC that addresses the instruction ROM and the IR feeding the decoder.
// Build with FETCH_PERF_EN defined to add the cycle_count/fetch_count performance counters.
module fetch_unit #(
    parameter int                   ADDR_W   = 8,
    parameter int                   INSTR_W  = 9,
    parameter logic [3:0]           HALT_OP  = 4'b1111,
    parameter logic [INSTR_W-1:0]   NOP_WORD = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_instr,
    output logic [INSTR_W-1:0]  ir,
    output logic [ADDR_W-1:0]   ir_pc,
    output logic                ir_valid,
    output logic                running,
    output logic                done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]         cycle_count,
    output logic [15:0]         fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic                is_halt;

    assign is_halt  = (rom_instr[INSTR_W-1 -: 4] == HALT_OP);
    assign rom_addr = pc;
    assign running  = (state == RUN);
    assign done     = (state == HALT);

    // Redirect squashes the word at the current PC, so it outranks stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            ir       <= NOP_WORD;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            state    <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= start_addr;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        pc       <= redirect_addr;
                        ir       <= NOP_WORD;
                        ir_valid <= 1'b0;
                    end else if (!stall) begin
                        ir       <= rom_instr;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        if (is_halt) begin
                            state <= HALT;
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                HALT: begin
                    ir_valid <= 1'b0;
                    if (start) begin
                        pc    <= start_addr;
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Counters restart on any accepted start and saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            fetch_count <= '0;
        end else if (start && (state != RUN)) begin
            cycle_count <= '0;
            fetch_count <= '0;
        end else if (state == RUN) begin
            if (cycle_count != 16'hFFFF) begin
                cycle_count <= cycle_count + 16'd1;
            end
            if (!redirect && !stall && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main fetch/stall/redirect stream,
// plus hand-written sequences for halt/restart, PC wrap and reset mid-run.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  rom_addr;
    logic [8:0]  rom_instr;
    logic [8:0]  ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        running;
    logic        done;
`ifdef FETCH_PERF_EN
    logic [15:0] cycle_count;
    logic [15:0] fetch_count;
`endif

    logic [8:0]  rom [256];

    int numChecks;
    int numFails;

    typedef struct {
        logic       start;
        logic [7:0] start_addr;
        logic       stall;
        logic       redirect;
        logic [7:0] redirect_addr;
        logic [7:0] exp_addr;
        logic [8:0] exp_ir;
        logic [7:0] exp_ir_pc;
        logic       exp_valid;
        logic       exp_running;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .rom_addr      (rom_addr),
        .rom_instr     (rom_instr),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .running       (running),
        .done          (done)
`ifdef FETCH_PERF_EN
        ,
        .cycle_count   (cycle_count),
        .fetch_count   (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_instr = rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [7:0] sa, input logic sl,
                                 input logic rd, input logic [7:0] ra);
        start         = st;
        start_addr    = sa;
        stall         = sl;
        redirect      = rd;
        redirect_addr = ra;
        tick();
        start    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] ea, input logic [8:0] eir,
                               input logic [7:0] epc, input logic ev, input logic er, input logic ed);
        numChecks++;
        if (rom_addr !== ea || ir !== eir || ir_pc !== epc || ir_valid !== ev ||
            running !== er || done !== ed) begin
            numFails++;
            $display("[TB] FAIL %s: got rom_addr=%0d ir=%h ir_pc=%0d ir_valid=%b running=%b done=%b, expected rom_addr=%0d ir=%h ir_pc=%0d ir_valid=%b running=%b done=%b",
                     name, rom_addr, ir, ir_pc, ir_valid, running, done, ea, eir, epc, ev, er, ed);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic checkPerf(input string name, input logic [15:0] ec, input logic [15:0] ef);
        numChecks++;
        if (cycle_count !== ec || fetch_count !== ef) begin
            numFails++;
            $display("[TB] FAIL %s: got cycle_count=%0d fetch_count=%0d, expected cycle_count=%0d fetch_count=%0d",
                     name, cycle_count, fetch_count, ec, ef);
        end
    endtask
`endif

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
    endtask

    task automatic addVec(input logic st, input logic [7:0] sa, input logic sl, input logic rd,
                          input logic [7:0] ra, input logic [7:0] ea, input logic [8:0] eir,
                          input logic [7:0] epc, input logic ev, input logic er, input logic ed);
        vec_t v;
        v.start = st;  v.start_addr = sa;  v.stall = sl;  v.redirect = rd;  v.redirect_addr = ra;
        v.exp_addr = ea;  v.exp_ir = eir;  v.exp_ir_pc = epc;
        v.exp_valid = ev;  v.exp_running = er;  v.exp_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        reset = 1'b0;  start = 1'b0;  start_addr = '0;  stall = 1'b0;
        redirect = 1'b0;  redirect_addr = '0;
        // Every word is its own address; opcode field never reaches 4'b1111.
        for (int i = 0; i < 256; i++) rom[i] = 9'(i);

        // Main stream: idle-ignore, start, sequential fetch, stall, redirect, redirect+stall, start ignored.
        addVec(0, 8'd0,   1, 1, 8'd50, 8'd0, 9'd0, 8'd0, 0, 0, 0);
        addVec(1, 8'd0,   0, 0, 8'd0,  8'd0, 9'd0, 8'd0, 0, 1, 0);
        for (int i = 1; i <= 5; i++)
            addVec(0, 8'd0, 0, 0, 8'd0, 8'(i), 9'(i - 1), 8'(i - 1), 1, 1, 0);
        for (int i = 0; i < 3; i++)
            addVec(0, 8'd0, 1, 0, 8'd0, 8'd5, 9'd4, 8'd4, 1, 1, 0);
        for (int a = 6; a <= 15; a++)
            addVec(0, 8'd0, 0, 0, 8'd0, 8'(a), 9'(a - 1), 8'(a - 1), 1, 1, 0);
        addVec(0, 8'd0,   0, 1, 8'd0,  8'd0, 9'd0, 8'd14, 0, 1, 0);
        addVec(0, 8'd0,   0, 0, 8'd0,  8'd1, 9'd0, 8'd0,  1, 1, 0);
        addVec(0, 8'd0,   0, 0, 8'd0,  8'd2, 9'd1, 8'd1,  1, 1, 0);
        addVec(0, 8'd0,   1, 1, 8'd0,  8'd0, 9'd0, 8'd1,  0, 1, 0);
        addVec(0, 8'd0,   0, 0, 8'd0,  8'd1, 9'd0, 8'd0,  1, 1, 0);
        addVec(1, 8'd100, 0, 0, 8'd0,  8'd2, 9'd1, 8'd1,  1, 1, 0);

        doReset();
        checkOutput("reset", 8'd0, 9'd0, 8'd0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        checkPerf("perf_reset", 16'd0, 16'd0);
`endif

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].start, vecs[k].start_addr, vecs[k].stall,
                          vecs[k].redirect, vecs[k].redirect_addr);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_addr, vecs[k].exp_ir,
                        vecs[k].exp_ir_pc, vecs[k].exp_valid, vecs[k].exp_running, vecs[k].exp_done);
        end
`ifdef FETCH_PERF_EN
        // 24 RUN cycles, of which 19 loaded a valid word.
        checkPerf("perf_stream", 16'd24, 16'd19);
`endif

        // Halt at address 3, redirect ignored in HALT, then restart at 8.
        rom[3] = 9'b1111_00000;
        doReset();
        applyStimulus(1, 8'd0, 0, 0, 8'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("pre_halt", 8'd3, 9'd2, 8'd2, 1, 1, 0);
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("halt_word", 8'd3, 9'b1111_00000, 8'd3, 1, 0, 1);
        applyStimulus(0, 8'd0, 0, 1, 8'd9);
        checkOutput("halted_1", 8'd3, 9'b1111_00000, 8'd3, 0, 0, 1);
        applyStimulus(0, 8'd0, 1, 0, 8'd0);
        checkOutput("halted_2", 8'd3, 9'b1111_00000, 8'd3, 0, 0, 1);
`ifdef FETCH_PERF_EN
        checkPerf("perf_halted", 16'd4, 16'd4);
`endif
        applyStimulus(1, 8'd8, 0, 0, 8'd0);
        checkOutput("restart", 8'd8, 9'b1111_00000, 8'd3, 0, 1, 0);
`ifdef FETCH_PERF_EN
        checkPerf("perf_restart", 16'd0, 16'd0);
`endif
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("restart_fetch", 8'd9, 9'd8, 8'd8, 1, 1, 0);
        rom[3] = 9'd3;

        // PC wrap from 255 to 0.
        doReset();
        applyStimulus(1, 8'd254, 0, 0, 8'd0);
        checkOutput("wrap_start", 8'd254, 9'd0, 8'd0, 0, 1, 0);
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("wrap_254", 8'd255, 9'd254, 8'd254, 1, 1, 0);
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("wrap_255", 8'd0, 9'd255, 8'd255, 1, 1, 0);
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("wrap_0", 8'd1, 9'd0, 8'd0, 1, 1, 0);
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("wrap_1", 8'd2, 9'd1, 8'd1, 1, 1, 0);

        // Reset in the middle of a run at PC=7.
        doReset();
        applyStimulus(1, 8'd0, 0, 0, 8'd0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkOutput("pc7", 8'd7, 9'd6, 8'd6, 1, 1, 0);
        reset = 1'b1;
        applyStimulus(1, 8'd40, 0, 0, 8'd0);
        reset = 1'b0;
        checkOutput("mid_reset", 8'd0, 9'd0, 8'd0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        checkPerf("perf_mid_reset", 16'd0, 16'd0);
        applyStimulus(1, 8'd0, 0, 0, 8'd0);
        checkPerf("perf_after_start", 16'd0, 16'd0);
        applyStimulus(0, 8'd0, 0, 0, 8'd0);
        checkPerf("perf_first_fetch", 16'd1, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
